// File: rtl/vga_plot_queue.sv
// vga_plot_queue: buffered pixel-plot front end for the VGA adapter.
// Plot requests are queued in a small FIFO and drained at one pixel per
// clock. A full-screen clear engine sweeps every pixel in x-fastest order
// while the queue keeps accepting (but not emitting) requests.
// Optional build macro VGA_PLOT_CLIP_COUNT_EN adds a saturating 16-bit
// count of out-of-range requests (clip_count), cleared by an accepted clear.
`timescale 1ns/1ps
module vga_plot_queue #(
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int COL_W      = 3,
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [X_W-1:0]   req_x,
    input  logic [Y_W-1:0]   req_y,
    input  logic [COL_W-1:0] req_colour,
    input  logic             clear_start,
    input  logic [COL_W-1:0] clear_colour,
    output logic             clear_busy,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [COL_W-1:0] vga_colour,
    output logic             vga_write
`ifdef VGA_PLOT_CLIP_COUNT_EN
    ,
    output logic [15:0]      clip_count
`endif
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int ENTRY_W = X_W + Y_W + COL_W;
    localparam int XW1     = X_W + 1;
    localparam int YW1     = Y_W + 1;
    localparam int CNT_W   = DEPTH_LOG2 + 1;

    // Limits carry one extra bit so H_RES == 2^X_W still compares correctly.
    localparam logic [X_W:0]        H_LIM    = XW1'(H_RES);
    localparam logic [Y_W:0]        V_LIM    = YW1'(V_RES);
    localparam logic [X_W-1:0]      X_LAST   = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]      Y_LAST   = Y_W'(V_RES - 1);
    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1'b1);
    localparam logic [X_W-1:0]      X_ONE    = X_W'(1'b1);
    localparam logic [Y_W-1:0]      Y_ONE    = Y_W'(1'b1);

    typedef enum logic [0:0] {
        ST_DRAIN = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [ENTRY_W-1:0]      mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_r;
    logic [DEPTH_LOG2-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic [COL_W-1:0]        fill_r;
    logic [X_W-1:0]          cx_r;
    logic [Y_W-1:0]          cy_r;
    logic                    accept_s;
    logic                    in_range_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    clear_go_s;
    logic                    last_px_s;
    logic [ENTRY_W-1:0]      head_s;

    assign req_ready  = (count_r != FULL_CNT);
    assign clear_busy = (state_r == ST_CLEAR);
    assign accept_s   = req_valid && req_ready;
    assign in_range_s = ({1'b0, req_x} < H_LIM) && ({1'b0, req_y} < V_LIM);
    assign push_s     = accept_s && in_range_s;
    // Queue is frozen during a sweep so queued pixels land on top of the fill.
    assign pop_s      = (state_r == ST_DRAIN) && (count_r != {CNT_W{1'b0}});
    // A clear request during a sweep is ignored entirely.
    assign clear_go_s = clear_start && (state_r == ST_DRAIN);
    assign last_px_s  = (cx_r == X_LAST) && (cy_r == Y_LAST);
    assign head_s     = mem_r[rd_ptr_r];

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_DRAIN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: enter the sweep on clear_start, leave after the last pixel.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_DRAIN: begin
                if (clear_start) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_CLEAR: begin
                if (last_px_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            default: state_next_s = ST_DRAIN;
        endcase
    end

    // FIFO storage, pointers and occupancy count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {req_x, req_y, req_colour};
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Pixel output register and clear sweep counters.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vga_x      <= {X_W{1'b0}};
            vga_y      <= {Y_W{1'b0}};
            vga_colour <= {COL_W{1'b0}};
            vga_write  <= 1'b0;
            fill_r     <= {COL_W{1'b0}};
            cx_r       <= {X_W{1'b0}};
            cy_r       <= {Y_W{1'b0}};
        end else begin
            case (state_r)
                ST_DRAIN: begin
                    if (pop_s) begin
                        {vga_x, vga_y, vga_colour} <= head_s;
                        vga_write                  <= 1'b1;
                    end else begin
                        vga_write <= 1'b0;
                    end
                    if (clear_go_s) begin
                        fill_r <= clear_colour;
                        cx_r   <= {X_W{1'b0}};
                        cy_r   <= {Y_W{1'b0}};
                    end
                end
                ST_CLEAR: begin
                    vga_x      <= cx_r;
                    vga_y      <= cy_r;
                    vga_colour <= fill_r;
                    vga_write  <= 1'b1;
                    if (last_px_s) begin
                        cx_r <= {X_W{1'b0}};
                        cy_r <= {Y_W{1'b0}};
                    end else if (cx_r == X_LAST) begin
                        cx_r <= {X_W{1'b0}};
                        cy_r <= cy_r + Y_ONE;
                    end else begin
                        cx_r <= cx_r + X_ONE;
                    end
                end
                default: begin
                    vga_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_PLOT_CLIP_COUNT_EN
    logic [15:0] clip_count_r;

    assign clip_count = clip_count_r;

    // Saturating count of accepted-but-discarded out-of-range requests.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clip_count_r <= 16'h0000;
        end else if (clear_go_s) begin
            clip_count_r <= 16'h0000;
        end else if (accept_s && !in_range_s && (clip_count_r != 16'hFFFF)) begin
            clip_count_r <= clip_count_r + 16'h0001;
        end else begin
            clip_count_r <= clip_count_r;
        end
    end
`endif

endmodule

// File: tb/tb_vga_plot_queue.sv
// Scoreboard bench for vga_plot_queue: stimulus pushes expected pixels,
// a negedge monitor pops and compares every vga_write.
`timescale 1ns/1ps
module tb_vga_plot_queue;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;
    localparam int H_RES = 160;
    localparam int V_RES = 120;
    localparam int NPIX  = H_RES * V_RES;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [X_W-1:0]   req_x = 8'd0;
    logic [Y_W-1:0]   req_y = 7'd0;
    logic [COL_W-1:0] req_colour = 3'd0;
    logic             clear_start = 1'b0;
    logic [COL_W-1:0] clear_colour = 3'd0;
    logic             clear_busy;
    logic [X_W-1:0]   vga_x;
    logic [Y_W-1:0]   vga_y;
    logic [COL_W-1:0] vga_colour;
    logic             vga_write;
`ifdef VGA_PLOT_CLIP_COUNT_EN
    logic [15:0]      clip_count;
`endif

    int checks = 0;
    int failures = 0;
    int write_count = 0;
    int ready_waits = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;

    vga_plot_queue dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
        .clear_start(clear_start), .clear_colour(clear_colour),
        .clear_busy(clear_busy),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_write(vga_write)
`ifdef VGA_PLOT_CLIP_COUNT_EN
        , .clip_count(clip_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [17:0] pk(input int x, input int y, input int c);
        logic [7:0] xv;
        logic [6:0] yv;
        logic [2:0] cv;
        xv = x[7:0];
        yv = y[6:0];
        cv = c[2:0];
        return {xv, yv, cv};
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every write must match the oldest expected pixel.
    always @(negedge clock) begin
        if (resetn && vga_write) begin
            write_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual=(%0d,%0d,%0d) required=none",
                         vga_x, vga_y, vga_colour);
            end else begin
                mon_e = exp_q.pop_front();
                if ({vga_x, vga_y, vga_colour} !== mon_e) begin
                    failures++;
                    $display("FAIL pixel actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                             vga_x, vga_y, vga_colour, mon_e[17:10], mon_e[9:3], mon_e[2:0]);
                end
            end
        end
    end

    // Present one request; returns just after the accepting edge (valid left high).
    task automatic send(input int x, input int y, input int c);
        int budget;
        @(negedge clock);
        req_valid = 1'b1;
        req_x = x[7:0];
        req_y = y[6:0];
        req_colour = c[2:0];
        budget = 0;
        while (!req_ready && budget < 30000) begin
            @(negedge clock);
            budget++;
        end
        if (budget > 0) ready_waits++;
        if (budget >= 30000) check("send_timeout", budget, 0);
        @(posedge clock);
        if (x < H_RES && y < V_RES) exp_q.push_back(pk(x, y, c));
    endtask

    task automatic idle();
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // Pulse clear_start and queue the full expected sweep; returns just after edge k.
    task automatic start_clear(input int colour);
        @(negedge clock);
        clear_start = 1'b1;
        clear_colour = colour[2:0];
        for (int y = 0; y < V_RES; y++)
            for (int x = 0; x < H_RES; x++)
                exp_q.push_back(pk(x, y, colour));
        @(posedge clock);
        #1;
        clear_start = 1'b0;
        check("clear_busy_rise", int'(clear_busy), 1);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        int cycles;
        int b;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_write", int'(vga_write), 0);
        check("rst_x", int'(vga_x), 0);
        check("rst_y", int'(vga_y), 0);
        check("rst_colour", int'(vga_colour), 0);
        check("rst_busy", int'(clear_busy), 0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("rst_ready", int'(req_ready), 1);
`ifdef VGA_PLOT_CLIP_COUNT_EN
        check("rst_clip", int'(clip_count), 0);
`endif

        // Single request latency
        send(5, 7, 5);
        idle();
        #1;
        check("lat_edge_k", int'(vga_write), 0);
        @(negedge clock);
        #1;
        check("lat_write", int'(vga_write), 1);
        check("lat_x", int'(vga_x), 5);
        check("lat_y", int'(vga_y), 7);
        check("lat_colour", int'(vga_colour), 5);
        @(negedge clock);
        #1;
        check("lat_after", int'(vga_write), 0);

        // 20 back-to-back requests
        wc = write_count;
        ready_waits = 0;
        for (int i = 0; i < 20; i++) send(i * 7, i * 5 + 1, i % 8);
        idle();
        #1;
        check("b2b_writes_by_last_accept", write_count - wc, 19);
        repeat (4) @(negedge clock);
        #1;
        check("b2b_writes", write_count - wc, 20);
        check("b2b_ready_drops", ready_waits, 0);
        check("b2b_drained", exp_q.size(), 0);

        // Full clear, with an ignored clear_start mid-sweep
        wc = write_count;
        start_clear(2);
        cycles = 0;
        while (clear_busy && cycles < 25000) begin
            if (cycles == 100) begin
                clear_start = 1'b1;
                clear_colour = 3'd7;
            end else begin
                clear_start = 1'b0;
            end
            @(posedge clock);
            #1;
            cycles++;
        end
        clear_start = 1'b0;
        check("clear_busy_cycles", cycles, NPIX);
        @(negedge clock);
        #1;
        check("clear_writes", write_count - wc, NPIX);
        check("clear_drained", exp_q.size(), 0);
        repeat (3) @(negedge clock);
        #1;
        check("clear_quiet", write_count - wc, NPIX);

        // Clear with 9 requests queued behind it
        start_clear(6);
        for (int i = 0; i < 8; i++) send(10 + i, 20 + i, i);
        idle();
        #1;
        check("fifo_full_ready", int'(req_ready), 0);
        check("fifo_full_busy", int'(clear_busy), 1);
        send(100, 100, 3);
        #1;
        check("ninth_after_clear", int'(clear_busy), 0);
        idle();
        b = 0;
        while (exp_q.size() > 0 && b < 30000) begin
            @(negedge clock);
            b++;
        end
        #1;
        check("queued_drained", exp_q.size(), 0);

        // Out-of-range requests plus the in-range corner
        wc = write_count;
        send(160, 0, 1);
        send(0, 120, 2);
        send(159, 119, 4);
        idle();
        repeat (4) @(negedge clock);
        #1;
        check("oor_writes", write_count - wc, 1);
        check("oor_drained", exp_q.size(), 0);
`ifdef VGA_PLOT_CLIP_COUNT_EN
        check("clip_count", int'(clip_count), 2);
`endif

        // Reset in the middle of a sweep
        start_clear(1);
        repeat (500) @(posedge clock);
        @(negedge clock);
        #1;
        check("midclear_remaining", exp_q.size(), NPIX - 500);
        resetn = 1'b0;
        #1;
        check("midrst_write", int'(vga_write), 0);
        check("midrst_busy", int'(clear_busy), 0);
        exp_q.delete();
        wc = write_count;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (50) @(negedge clock);
        #1;
        check("post_rst_quiet", write_count - wc, 0);
        check("post_rst_busy", int'(clear_busy), 0);
        send(1, 2, 3);
        idle();
        repeat (3) @(negedge clock);
        #1;
        check("post_rst_write", write_count - wc, 1);
        check("post_rst_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
